// File: rtl/ps2_mouse_rx_pkg.sv
// Shared types and constants for the PS/2 mouse receiver.
// Frame FSM encoding, byte0 field positions and the cursor clamp helper.
package ps2_mouse_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } frame_st_e;

    localparam int PS2_FRAME_BITS = 11;

    localparam int ALIGN_BIT = 3;
    localparam int XSGN_BIT  = 4;
    localparam int YSGN_BIT  = 5;
    localparam int XOV_BIT   = 6;
    localparam int YOV_BIT   = 7;

    typedef struct packed {
        logic       yov;
        logic       xov;
        logic       ysgn;
        logic       xsgn;
        logic [2:0] btn;
    } hdr_t;

    function automatic logic [11:0] sext12(input logic [8:0] v);
        return {{3{v[8]}}, v};
    endfunction

    function automatic logic [9:0] clamp10(
        input logic signed [11:0] v,
        input logic        [9:0]  hi
    );
        if (v < 0) begin
            return '0;
        end else if (v > $signed({2'b00, hi})) begin
            return hi;
        end
        return v[9:0];
    endfunction

endpackage

// File: rtl/ps2_mouse_rx_if.sv
// PS/2 line inputs and decoded mouse outputs.
// slave: the receiver; master: whoever drives the PS/2 lines and reads results.
interface ps2_mouse_rx_if;

    logic       PS2_CLK;
    logic       PS2_DATA;
    logic [2:0] BTN;
    logic [8:0] DX;
    logic [8:0] DY;
    logic [9:0] CURSOR_X;
    logic [9:0] CURSOR_Y;
    logic       PKT_VALID;
    logic       FRAME_ERR;

    modport slave (
        input  PS2_CLK,
        input  PS2_DATA,
        output BTN,
        output DX,
        output DY,
        output CURSOR_X,
        output CURSOR_Y,
        output PKT_VALID,
        output FRAME_ERR
    );

    modport master (
        output PS2_CLK,
        output PS2_DATA,
        input  BTN,
        input  DX,
        input  DY,
        input  CURSOR_X,
        input  CURSOR_Y,
        input  PKT_VALID,
        input  FRAME_ERR
    );

endinterface

// File: rtl/ps2_mouse_rx_frame_rx.sv
// PS/2 frame deserialiser: line sync, clock glitch filter, falling-edge
// strobe, start/data/parity/stop FSM and inter-bit timeout.
module ps2_frame_rx
    import ps2_mouse_rx_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FLT_TOP  = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMO_TOP  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]    LAST_BIT = 3'(PS2_FRAME_BITS - 4);

    logic [1:0]    clk_sync_q;
    logic [1:0]    dat_sync_q;
    logic          filt_q;
    logic [FW-1:0] flt_cnt_q;
    logic          flip;
    logic          strobe;
    logic          din;

    frame_st_e     state_q;
    logic [7:0]    shift_q;
    logic [2:0]    bit_q;
    logic          par_ok_q;
    logic [TW-1:0] tmo_q;
    logic [7:0]    byte_q;
    logic          bv_q;
    logic          err_q;

    assign din    = dat_sync_q[1];
    assign flip   = (clk_sync_q[1] != filt_q) && (flt_cnt_q == FLT_TOP);
    assign strobe = flip && filt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
            dat_sync_q <= {dat_sync_q[0], ps2_data_i};
        end
    end

    // Filtered clock only follows the line after FILTER_LEN differing samples.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            filt_q    <= 1'b1;
            flt_cnt_q <= '0;
        end else if (clk_sync_q[1] == filt_q) begin
            flt_cnt_q <= '0;
        end else if (flip) begin
            filt_q    <= ~filt_q;
            flt_cnt_q <= '0;
        end else begin
            flt_cnt_q <= flt_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            shift_q  <= '0;
            bit_q    <= '0;
            par_ok_q <= 1'b0;
            tmo_q    <= '0;
            byte_q   <= '0;
            bv_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            bv_q  <= 1'b0;
            err_q <= 1'b0;
            if (state_q == ST_IDLE || strobe) begin
                tmo_q <= '0;
            end else begin
                tmo_q <= tmo_q + 1'b1;
            end
            if (state_q != ST_IDLE && !strobe && tmo_q == TMO_TOP) begin
                err_q   <= 1'b1;
                state_q <= ST_IDLE;
            end else if (strobe) begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (din) begin
                            err_q <= 1'b1;
                        end else begin
                            state_q <= ST_DATA;
                            bit_q   <= '0;
                        end
                    end
                    ST_DATA: begin
                        shift_q <= {din, shift_q[7:1]};
                        bit_q   <= bit_q + 1'b1;
                        if (bit_q == LAST_BIT) begin
                            state_q <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        par_ok_q <= ^{shift_q, din};
                        state_q  <= ST_STOP;
                    end
                    ST_STOP: begin
                        if (din && par_ok_q) begin
                            bv_q   <= 1'b1;
                            byte_q <= shift_q;
                        end else begin
                            err_q <= 1'b1;
                        end
                        state_q <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign byte_o       = byte_q;
    assign byte_valid_o = bv_q;
    assign frame_err_o  = err_q;

endmodule

// File: rtl/ps2_mouse_rx.sv
// PS/2 mouse receiver top: 3-byte stream packet assembly, deltas,
// and an absolute cursor clamped to the screen.
module ps2_mouse_rx
    import ps2_mouse_rx_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int X_MAX          = 639,
    parameter int Y_MAX          = 479
) (
    input  logic          CLK_50M,
    input  logic          RST,
    ps2_mouse_rx_if.slave bus
);

    localparam logic [9:0] XM     = 10'(X_MAX);
    localparam logic [9:0] YM     = 10'(Y_MAX);
    localparam logic [9:0] X_HOME = 10'(X_MAX / 2);
    localparam logic [9:0] Y_HOME = 10'(Y_MAX / 2);

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_err;

    ps2_frame_rx #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_frame (
        .clk_i       (CLK_50M),
        .rst_i       (RST),
        .ps2_clk_i   (bus.PS2_CLK),
        .ps2_data_i  (bus.PS2_DATA),
        .byte_o      (rx_byte),
        .byte_valid_o(rx_valid),
        .frame_err_o (rx_err)
    );

    logic [1:0] idx_q;
    hdr_t       hdr_q;
    logic [7:0] x_q;
    logic [2:0] btn_q;
    logic [8:0] dx_q;
    logic [8:0] dy_q;
    logic [9:0] cx_q;
    logic [9:0] cy_q;
    logic       pkt_q;

    logic [8:0]        dx_d;
    logic [8:0]        dy_d;
    logic signed [11:0] cx_sum;
    logic signed [11:0] cy_sum;
    logic [9:0]        cx_d;
    logic [9:0]        cy_d;

    // Y byte is consumed straight off the deserialiser as it completes.
    always_comb begin
        dx_d   = hdr_q.xov ? '0 : {hdr_q.xsgn, x_q};
        dy_d   = hdr_q.yov ? '0 : {hdr_q.ysgn, rx_byte};
        cx_sum = $signed({2'b00, cx_q}) + $signed(sext12(dx_d));
        cy_sum = $signed({2'b00, cy_q}) - $signed(sext12(dy_d));
        cx_d   = clamp10(cx_sum, XM);
        cy_d   = clamp10(cy_sum, YM);
    end

    always_ff @(posedge CLK_50M) begin
        if (RST) begin
            idx_q <= '0;
            hdr_q <= '0;
            x_q   <= '0;
            btn_q <= '0;
            dx_q  <= '0;
            dy_q  <= '0;
            cx_q  <= X_HOME;
            cy_q  <= Y_HOME;
            pkt_q <= 1'b0;
        end else begin
            pkt_q <= 1'b0;
            if (rx_err) begin
                idx_q <= '0;
            end else if (rx_valid) begin
                unique case (idx_q)
                    2'd0: begin
                        if (rx_byte[ALIGN_BIT]) begin
                            hdr_q <= '{
                                yov:  rx_byte[YOV_BIT],
                                xov:  rx_byte[XOV_BIT],
                                ysgn: rx_byte[YSGN_BIT],
                                xsgn: rx_byte[XSGN_BIT],
                                btn:  rx_byte[2:0]
                            };
                            idx_q <= 2'd1;
                        end
                    end
                    2'd1: begin
                        x_q   <= rx_byte;
                        idx_q <= 2'd2;
                    end
                    2'd2: begin
                        btn_q <= hdr_q.btn;
                        dx_q  <= dx_d;
                        dy_q  <= dy_d;
                        cx_q  <= cx_d;
                        cy_q  <= cy_d;
                        pkt_q <= 1'b1;
                        idx_q <= 2'd0;
                    end
                    default: idx_q <= '0;
                endcase
            end
        end
    end

    assign bus.BTN       = btn_q;
    assign bus.DX        = dx_q;
    assign bus.DY        = dy_q;
    assign bus.CURSOR_X  = cx_q;
    assign bus.CURSOR_Y  = cy_q;
    assign bus.PKT_VALID = pkt_q;
    assign bus.FRAME_ERR = rx_err;

endmodule

// File: tb/tb_ps2_mouse_rx.sv
// Self-checking bench for ps2_mouse_rx: vector table, corner sequences,
// and randomized packets against an integer cursor model.
module tb_ps2_mouse_rx;

    localparam int HP   = 20;
    localparam int GAP  = 60;
    localparam int TMO  = 200;
    localparam int XM   = 639;
    localparam int YM   = 479;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #10 clk = ~clk;

    ps2_mouse_rx_if bus ();

    ps2_mouse_rx #(
        .FILTER_LEN    (8),
        .TIMEOUT_CYCLES(TMO),
        .X_MAX         (XM),
        .Y_MAX         (YM)
    ) dut (
        .CLK_50M(clk),
        .RST    (rst),
        .bus    (bus)
    );

    int pass_n   = 0;
    int total_n  = 0;
    int pkt_cnt  = 0;
    int err_cnt  = 0;
    int both_cnt = 0;
    int mx;
    int my;

    always @(negedge clk) begin
        if (bus.PKT_VALID) pkt_cnt++;
        if (bus.FRAME_ERR) err_cnt++;
        if (bus.PKT_VALID && bus.FRAME_ERR) both_cnt++;
    end

    task automatic chk(input string name, input int act, input int exp);
        total_n++;
        if (act == exp) begin
            pass_n++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send_bits(input logic [7:0] b, input bit bad_par,
                             input int nbits);
        logic [10:0] fr;
        fr = {1'b1, (~(^b)) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            bus.PS2_DATA = fr[i];
            repeat (HP / 2) @(negedge clk);
            bus.PS2_CLK = 1'b0;
            repeat (HP) @(negedge clk);
            bus.PS2_CLK = 1'b1;
            repeat (HP / 2) @(negedge clk);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_par);
        send_bits(b, bad_par, 11);
        bus.PS2_DATA = 1'b1;
        repeat (GAP) @(negedge clk);
    endtask

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2);
        send_byte(b0, 1'b0);
        send_byte(b1, 1'b0);
        send_byte(b2, 1'b0);
    endtask

    task automatic expect_pkt(input string n, input int p0, input int btn,
                              input int dx, input int dy, input int cx,
                              input int cy);
        chk({n, ".pkt"}, pkt_cnt - p0, 1);
        chk({n, ".btn"}, int'(bus.BTN), btn);
        chk({n, ".dx"}, int'(bus.DX), dx & 'h1FF);
        chk({n, ".dy"}, int'(bus.DY), dy & 'h1FF);
        chk({n, ".cx"}, int'(bus.CURSOR_X), cx);
        chk({n, ".cy"}, int'(bus.CURSOR_Y), cy);
    endtask

    task automatic do_reset();
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
    endtask

    function automatic int clampi(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic int delta(input logic ov, input logic sgn,
                                 input logic [7:0] m);
        if (ov) return 0;
        return sgn ? int'(m) - 256 : int'(m);
    endfunction

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        int         btn;
        int         dx;
        int         dy;
        int         cx;
        int         cy;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int p0;
        int e0;
        int w;
        int r;
        int dxm;
        int dym;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;

        tbl[0] = '{8'h18, 8'hFB, 8'h00, 0,  -5,    0, 314, 239};
        tbl[1] = '{8'h09, 8'h05, 8'h03, 1,   5,    3, 319, 236};
        tbl[2] = '{8'h0A, 8'h00, 8'h00, 2,   0,    0, 319, 236};
        tbl[3] = '{8'h2C, 8'h10, 8'hF0, 4,  16,  -16, 335, 252};
        tbl[4] = '{8'h48, 8'h7F, 8'h02, 0,   0,    2, 335, 250};
        tbl[5] = '{8'h89, 8'h01, 8'h55, 1,   1,    0, 336, 250};
        tbl[6] = '{8'h28, 8'h00, 8'h80, 0,   0, -128, 336, 378};
        tbl[7] = '{8'h28, 8'h00, 8'h80, 0,   0, -128, 336, 479};

        bus.PS2_CLK  = 1'b1;
        bus.PS2_DATA = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("rst.btn", int'(bus.BTN), 0);
        chk("rst.dx", int'(bus.DX), 0);
        chk("rst.dy", int'(bus.DY), 0);
        chk("rst.cx", int'(bus.CURSOR_X), 319);
        chk("rst.cy", int'(bus.CURSOR_Y), 239);
        chk("rst.pkt", int'(bus.PKT_VALID), 0);
        chk("rst.err", int'(bus.FRAME_ERR), 0);

        e0 = err_cnt;
        for (int i = 0; i < 8; i++) begin
            p0 = pkt_cnt;
            send_pkt(tbl[i].b0, tbl[i].b1, tbl[i].b2);
            expect_pkt($sformatf("tbl%0d", i), p0, tbl[i].btn, tbl[i].dx,
                       tbl[i].dy, tbl[i].cx, tbl[i].cy);
        end
        chk("tbl.no_err", err_cnt - e0, 0);

        // Bad parity mid-packet, then resync
        e0 = err_cnt;
        p0 = pkt_cnt;
        send_byte(8'h09, 1'b0);
        send_byte(8'h05, 1'b1);
        chk("par.err", err_cnt - e0, 1);
        chk("par.no_pkt", pkt_cnt - p0, 0);
        p0 = pkt_cnt;
        send_pkt(8'h08, 8'h01, 8'h01);
        expect_pkt("par.resync", p0, 0, 1, 1, 337, 478);

        // Stray unaligned byte dropped silently
        e0 = err_cnt;
        p0 = pkt_cnt;
        send_byte(8'h00, 1'b0);
        send_pkt(8'h08, 8'h01, 8'h01);
        expect_pkt("stray", p0, 0, 1, 1, 338, 477);
        chk("stray.no_err", err_cnt - e0, 0);

        // Clamps at both ends and exact boundaries
        do_reset();
        for (int i = 0; i < 3; i++) send_pkt(8'h18, 8'h81, 8'h7F);
        chk("clamp.lo.cx", int'(bus.CURSOR_X), 0);
        chk("clamp.lo.cy", int'(bus.CURSOR_Y), 0);
        p0 = pkt_cnt;
        send_pkt(8'h18, 8'h9C, 8'h00);
        expect_pkt("clamp.m100", p0, 0, -100, 0, 0, 0);
        for (int i = 0; i < 3; i++) send_pkt(8'h08, 8'hFF, 8'h00);
        chk("clamp.hi.cx", int'(bus.CURSOR_X), 639);
        p0 = pkt_cnt;
        send_pkt(8'h18, 8'hFF, 8'h00);
        expect_pkt("edge.m1", p0, 0, -1, 0, 638, 0);
        p0 = pkt_cnt;
        send_pkt(8'h08, 8'h01, 8'h00);
        expect_pkt("edge.p1", p0, 0, 1, 0, 639, 0);
        p0 = pkt_cnt;
        send_pkt(8'h48, 8'h10, 8'h00);
        expect_pkt("xov", p0, 0, 0, 0, 639, 0);

        // Clock stops mid-frame
        e0 = err_cnt;
        p0 = pkt_cnt;
        send_bits(8'h09, 1'b0, 5);
        bus.PS2_DATA = 1'b1;
        w = 0;
        while (w < TMO + 100 && err_cnt == e0) begin
            @(negedge clk);
            w++;
        end
        chk("tmo.err", err_cnt - e0, 1);
        chk("tmo.window", int'(w >= TMO - 60 && w <= TMO), 1);
        chk("tmo.no_pkt", pkt_cnt - p0, 0);
        repeat (GAP) @(negedge clk);
        p0 = pkt_cnt;
        send_pkt(8'h09, 8'h05, 8'h03);
        expect_pkt("tmo.after", p0, 1, 5, 3, 639, 0);

        // Reset in the middle of a packet
        send_byte(8'h09, 1'b0);
        send_bits(8'h05, 1'b0, 5);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        chk("mrst.btn", int'(bus.BTN), 0);
        chk("mrst.dx", int'(bus.DX), 0);
        chk("mrst.dy", int'(bus.DY), 0);
        chk("mrst.cx", int'(bus.CURSOR_X), 319);
        chk("mrst.cy", int'(bus.CURSOR_Y), 239);
        bus.PS2_DATA = 1'b1;
        repeat (GAP) @(negedge clk);
        p0 = pkt_cnt;
        send_pkt(8'h09, 8'h05, 8'h03);
        expect_pkt("mrst.after", p0, 1, 5, 3, 324, 236);

        // Short glitch on the clock line is filtered out
        e0 = err_cnt;
        p0 = pkt_cnt;
        bus.PS2_CLK = 1'b0;
        repeat (4) @(negedge clk);
        bus.PS2_CLK = 1'b1;
        repeat (30) @(negedge clk);
        chk("glitch.no_err", err_cnt - e0, 0);
        chk("glitch.no_pkt", pkt_cnt - p0, 0);

        // Randomized packets against the integer model
        do_reset();
        mx = XM / 2;
        my = YM / 2;
        for (int k = 0; k < 10; k++) begin
            e0 = err_cnt;
            r  = $urandom_range(0, 3);
            if (r == 0) begin
                b0 = 8'($urandom) & 8'hF7;
                send_byte(b0, 1'b0);
            end else if (r == 1) begin
                send_byte(8'($urandom) | 8'h08, 1'b0);
                send_byte(8'($urandom), 1'b1);
            end
            chk($sformatf("rnd%0d.err", k), err_cnt - e0, (r == 1) ? 1 : 0);
            b0 = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                  1'($urandom), 1'($urandom), 1'b1, 3'($urandom)};
            b1 = 8'($urandom);
            b2 = 8'($urandom);
            dxm = delta(b0[6], b0[4], b1);
            dym = delta(b0[7], b0[5], b2);
            mx = clampi(mx + dxm, XM);
            my = clampi(my - dym, YM);
            p0 = pkt_cnt;
            send_pkt(b0, b1, b2);
            expect_pkt($sformatf("rnd%0d", k), p0, int'(b0[2:0]), dxm, dym,
                       mx, my);
        end

        chk("pkt_err_exclusive", both_cnt, 0);
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end

endmodule
